// File: rtl/key_entry_ctrl_if.sv
// Keypad-to-datapath bundle: scanner key inputs, expression handshake, display.
// Pure wiring; no latency of its own.
// calc_valid/calc_ready handshake; the key inputs cannot be stalled.
interface key_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  key_en;
    logic [3:0]            key_value;
    logic                  calc_valid;
    logic                  calc_ready;
    logic [1:0]            calc_op;
    logic [4*DIGITS-1:0]   calc_a;
    logic [4*DIGITS-1:0]   calc_b;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  disp_sel;
    logic                  key_drop;
    logic                  timeout;

    // master: scanner + datapath side; slave: the entry controller
    modport master (
        output key_en, key_value, calc_ready,
        input  calc_valid, calc_op, calc_a, calc_b, disp_bcd, disp_sel, key_drop, timeout
    );

    modport slave (
        input  key_en, key_value, calc_ready,
        output calc_valid, calc_op, calc_a, calc_b, disp_bcd, disp_sel, key_drop, timeout
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: edge-detects presses, builds BCD operands A/B and operator.
// A press updates state one cycle later; key_drop/timeout are one-cycle pulses.
// Holds calc_valid until calc_ready; presses while waiting are dropped. Idle timer: KEY_ENTRY_TIMEOUT_EN.
module key_entry_ctrl #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk_slow,
    input  logic            rst,
    key_entry_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);
    localparam logic [NW-1:0] NMAX = NW'(DIGITS);

    typedef logic [$clog2(TIMEOUT + 1)-1:0] cnt_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            en_q;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [NW-1:0]   na_q, na_d, nb_q, nb_d;
    logic [1:0]      op_q, op_d;
    logic            drop_q, drop_d;

    logic            press;
    logic            is_digit, is_op, is_enter, is_del, is_zero;
    logic [1:0]      op_code;
    logic [W-1:0]    digit_ext;
    logic            expire;

    assign press     = bus.key_en & ~en_q;
    assign is_digit  = (bus.key_value <= 4'd9);
    assign is_enter  = (bus.key_value == 4'd13);
    assign is_del    = (bus.key_value == 4'd14);
    assign is_op     = ~is_digit & ~is_enter & ~is_del;
    assign is_zero   = (bus.key_value == 4'd0);
    assign digit_ext = W'(bus.key_value);

    // 10..12 map to 00..10 directly; 15 ('/') is the odd one out
    always_comb begin
        op_code = 2'b11;
        case (bus.key_value)
            4'd10:   op_code = 2'b00;
            4'd11:   op_code = 2'b01;
            4'd12:   op_code = 2'b10;
            default: op_code = 2'b11;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        na_d    = na_q;
        nb_d    = nb_q;
        op_d    = op_q;
        drop_d  = 1'b0;

        case (state_q)
            ENTER_A: begin
                if (press) begin
                    if (is_digit) begin
                        if (na_q == NMAX) begin
                            drop_d = 1'b1;
                        end else if (!(na_q == '0 && is_zero)) begin
                            a_d  = (a_q << 4) | digit_ext;
                            na_d = na_q + NW'(1);
                        end
                    end else if (is_del) begin
                        if (na_q != '0) begin
                            a_d  = a_q >> 4;
                            na_d = na_q - NW'(1);
                        end
                    end else if (is_op) begin
                        op_d    = op_code;
                        state_d = ENTER_B;
                    end
                end
            end

            ENTER_B: begin
                if (press) begin
                    if (is_digit) begin
                        if (nb_q == NMAX) begin
                            drop_d = 1'b1;
                        end else if (!(nb_q == '0 && is_zero)) begin
                            b_d  = (b_q << 4) | digit_ext;
                            nb_d = nb_q + NW'(1);
                        end
                    end else if (is_del) begin
                        if (nb_q != '0) begin
                            b_d  = b_q >> 4;
                            nb_d = nb_q - NW'(1);
                        end else begin
                            // empty B: backspace over the operator, A survives untouched
                            op_d    = 2'b00;
                            state_d = ENTER_A;
                        end
                    end else if (is_enter) begin
                        if (nb_q != '0) begin
                            state_d = OUTPUT;
                        end
                    end else if (nb_q == '0) begin
                        op_d = op_code;
                    end
                end
            end

            OUTPUT: begin
                if (press) begin
                    drop_d = 1'b1;
                end
                if (bus.calc_ready) begin
                    a_d     = '0;
                    b_d     = '0;
                    na_d    = '0;
                    nb_d    = '0;
                    state_d = ENTER_A;
                end
            end

            default: begin
                state_d = ENTER_A;
            end
        endcase

        if (expire) begin
            a_d     = '0;
            b_d     = '0;
            na_d    = '0;
            nb_d    = '0;
            state_d = ENTER_A;
        end
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state_q <= ENTER_A;
            en_q    <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            na_q    <= '0;
            nb_q    <= '0;
            op_q    <= 2'b00;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= bus.key_en;
            a_q     <= a_d;
            b_q     <= b_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            op_q    <= op_d;
            drop_q  <= drop_d;
        end
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    cnt_t  cnt_q, cnt_d;
    logic  counting;
    logic  tmo_q;

    assign counting = (state_q == ENTER_A && na_q != '0) || (state_q == ENTER_B);
    // fires on the edge where the count steps onto TIMEOUT-1; a press in that cycle wins
    assign expire   = counting && !press && ((int'(cnt_q) + 1) == (TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (press || expire || (state_d == ENTER_A && state_q != ENTER_A)) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= expire;
        end
    end

    assign bus.timeout = tmo_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.calc_valid = (state_q == OUTPUT);
    assign bus.calc_op    = op_q;
    assign bus.calc_a     = a_q;
    assign bus.calc_b     = b_q;
    assign bus.disp_bcd   = (state_q == ENTER_A) ? a_q : b_q;
    assign bus.disp_sel   = (state_q != ENTER_A);
    assign bus.key_drop   = drop_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Random and directed key sequences against a decimal-arithmetic model of the entry rules;
// completed expressions are queued and checked by a separate transfer monitor.
module tb_key_entry_ctrl;
    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 8;

    logic clk_slow = 1'b0;
    logic rst      = 1'b1;

    always #5 clk_slow = ~clk_slow;

    key_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();

    key_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clk_slow (clk_slow),
        .rst      (rst),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int drops_exp = 0;
    int drops_seen = 0;
    int tmo_seen = 0;

    // model: operands as plain decimal integers plus digit counts
    int ma_v, ma_n, mb_v, mb_n, m_op, m_st;  // m_st: 0 entering A, 1 entering B, 2 waiting

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int opc(input int k);
        case (k)
            10:      return 0;
            11:      return 1;
            12:      return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_clear();
        ma_v = 0; ma_n = 0; mb_v = 0; mb_n = 0; m_st = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_op = 0;
        q.delete();
    endtask

    task automatic add_digit(inout int v, inout int n, input int d);
        if (n == DIGITS) drops_exp++;
        else if (!(n == 0 && d == 0)) begin
            v = v * 10 + d;
            n++;
        end
    endtask

    task automatic model_press(input int k);
        case (m_st)
            0: begin
                if (k <= 9) add_digit(ma_v, ma_n, k);
                else if (k == 14) begin
                    if (ma_n > 0) begin ma_v = ma_v / 10; ma_n--; end
                end else if (k != 13) begin
                    m_op = opc(k);
                    m_st = 1;
                end
            end
            1: begin
                if (k <= 9) add_digit(mb_v, mb_n, k);
                else if (k == 14) begin
                    if (mb_n > 0) begin mb_v = mb_v / 10; mb_n--; end
                    else m_st = 0;
                end else if (k == 13) begin
                    if (mb_n > 0) begin
                        q.push_back('{to_bcd(ma_v), to_bcd(mb_v), 2'(m_op)});
                        m_st = 2;
                    end
                end else if (mb_n == 0) m_op = opc(k);
            end
            default: drops_exp++;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_slow);
        #2;
    endtask

    task automatic press(input int k, input int hold);
        tick();
        bus.key_en = 1'b1;
        bus.key_value = 4'(k);
        model_press(k);
        if (m_st == 2 && bus.calc_ready) model_clear();
        repeat (hold) tick();
        bus.key_en = 1'b0;
        tick();
        @(negedge clk_slow);
        chk("disp", {15'b0, bus.disp_sel, bus.disp_bcd},
            {15'b0, (m_st != 0), to_bcd((m_st == 0) ? ma_v : mb_v)});
    endtask

    task automatic accept();
        tick();
        bus.calc_ready = 1'b1;
        tick();
        bus.calc_ready = 1'b0;
        model_clear();
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk_slow) begin
        if (!rst) begin
            if (bus.calc_valid && bus.calc_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got a transfer, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("xfer_a", 32'(bus.calc_a), 32'(e.a));
                    chk("xfer_b", 32'(bus.calc_b), 32'(e.b));
                    chk("xfer_op", 32'(bus.calc_op), 32'(e.op));
                end
            end
            if (bus.key_drop) drops_seen++;
            if (bus.timeout) tmo_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tmo_idx;
        bus.key_en = 1'b0;
        bus.key_value = 4'd0;
        bus.calc_ready = 1'b0;
        model_reset();

        repeat (2) tick();
        @(negedge clk_slow);
        chk("rst_valid", 32'(bus.calc_valid), 0);
        chk("rst_a", 32'(bus.calc_a), 0);
        chk("rst_b", 32'(bus.calc_b), 0);
        chk("rst_op", 32'(bus.calc_op), 0);
        chk("rst_disp", {15'b0, bus.disp_sel, bus.disp_bcd}, 0);
        chk("rst_pulses", {30'b0, bus.key_drop, bus.timeout}, 0);
        tick();
        rst = 1'b0;

        // basic expression 12 + 3
        press(1, 1); press(2, 1); press(10, 1); press(3, 1); press(13, 1);
        chk("t1_valid", 32'(bus.calc_valid), 1);
        repeat (3) tick();
        @(negedge clk_slow);
        chk("t1_hold_valid", 32'(bus.calc_valid), 1);
        chk("t1_a", 32'(bus.calc_a), 32'h0012);
        chk("t1_b", 32'(bus.calc_b), 32'h0003);
        chk("t1_op", 32'(bus.calc_op), 0);
        accept();
        @(negedge clk_slow);
        chk("t1_done_valid", 32'(bus.calc_valid), 0);
        chk("t1_done_disp", 32'(bus.disp_bcd), 0);

        // overflow and delete
        reset_dut();
        press(9, 1); press(8, 2); press(7, 1); press(6, 1); press(5, 1);
        chk("t2_full", 32'(bus.disp_bcd), 32'h9876);
        chk("t2_drops", drops_seen, drops_exp);
        press(14, 1);
        chk("t2_del", 32'(bus.disp_bcd), 32'h0987);

        // leading zeros, operator replace, cancel
        reset_dut();
        press(0, 1); press(0, 1); press(7, 1);
        chk("t3_lz", 32'(bus.disp_bcd), 32'h0007);
        press(12, 1); press(15, 1); press(14, 1);
        chk("t3_cancel", {15'b0, bus.disp_sel, bus.disp_bcd}, 32'h0007);

        // held key gives exactly one digit
        reset_dut();
        tick();
        bus.key_en = 1'b1;
        bus.key_value = 4'd5;
        model_press(5);
        repeat (3) tick();
        @(negedge clk_slow);
        chk("t4_held", 32'(bus.disp_bcd), 32'h0005);
        repeat (17) tick();
        bus.key_en = 1'b0;
        tick();
        @(negedge clk_slow);
`ifdef KEY_ENTRY_TIMEOUT_EN
        chk("t4_held_end", 32'(bus.disp_bcd), 32'h0000);
`else
        chk("t4_held_end", 32'(bus.disp_bcd), 32'h0005);
`endif
        reset_dut();
        press(5, 1); press(11, 1); press(13, 1);
        chk("t4_empty_b", 32'(bus.calc_valid), 0);

        // press while waiting, then reset while valid
        reset_dut();
        press(1, 1); press(12, 1); press(2, 1); press(13, 1);
        press(3, 1);
        chk("t5_drop_a", 32'(bus.calc_a), 32'h0001);
        chk("t5_drops", drops_seen, drops_exp);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk_slow);
        chk("t5_rst_valid", 32'(bus.calc_valid), 0);
        chk("t5_rst_ops", {bus.calc_a, bus.calc_b}, 0);
        chk("t5_rst_op", 32'(bus.calc_op), 0);
        tick();
        rst = 1'b0;
        model_reset();

        // key held through reset
        tick();
        rst = 1'b1;
        bus.key_en = 1'b1;
        bus.key_value = 4'd7;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        bus.key_en = 1'b0;
        tick();
        @(negedge clk_slow);
        chk("t5_held_rst", {15'b0, bus.disp_sel, bus.disp_bcd}, 0);

        // ready already high when the expression completes
        reset_dut();
        bus.calc_ready = 1'b1;
        press(2, 1); press(10, 1); press(3, 1); press(13, 1);
        chk("t5_ready_first", 32'(bus.calc_valid), 0);
        bus.calc_ready = 1'b0;

        // idle timer
        reset_dut();
        tick();
        bus.key_en = 1'b1;
        bus.key_value = 4'd4;
        model_press(4);
        tick();
        bus.key_en = 1'b0;
        tmo_idx = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_slow);
            if (bus.timeout && tmo_idx < 0) tmo_idx = i;
        end
`ifdef KEY_ENTRY_TIMEOUT_EN
        chk("t6_tmo_cycle", tmo_idx, 8);
        model_clear();
`else
        chk("t6_tmo_cycle", tmo_idx, -1);
`endif
        chk("t6_disp", 32'(bus.disp_bcd), 32'(to_bcd(ma_v)));

        // randomized sessions
        reset_dut();
        for (int it = 0; it < 300; it++) begin
            int r, k;
            if (m_st == 2 && $urandom_range(0, 9) < 7) begin
                accept();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 55)      k = $urandom_range(0, 9);
                else if (r < 70) begin
                    k = $urandom_range(10, 13);
                    if (k == 13) k = 15;
                end
                else if (r < 82) k = 14;
                else             k = 13;
                press(k, $urandom_range(1, 2));
            end
            repeat ($urandom_range(0, 1)) tick();
        end
        if (m_st == 2) accept();
        repeat (2) tick();
        @(negedge clk_slow);
        chk("end_queue_empty", q.size(), 0);
        chk("end_drops", drops_seen, drops_exp);
`ifdef KEY_ENTRY_TIMEOUT_EN
        chk("end_timeouts", tmo_seen, 2);
`else
        chk("end_timeouts", tmo_seen, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
